// File: rtl/spi_rx_word_deser_if.sv
// Bundle between the serial RX pins and the parallel word output of the SPI RX deserialiser.
// The slave side is the deserialiser; the master side drives the serial stream.
interface spi_rx_word_deser_if #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned ADDR_W = 3
);
  logic              RX_DATA;
  logic              RX_LOAD;
  logic              RX_STOP;
  logic [ADDR_W-1:0] P_ADDR;
  logic [WORD_W-1:0] P_DATA;
  logic              P_ENA;
  logic              FRAME_ERR;
  logic [7:0]        ERR_CNT;

  modport master (
    output RX_DATA, RX_LOAD, RX_STOP,
    input  P_ADDR, P_DATA, P_ENA, FRAME_ERR, ERR_CNT
  );

  modport slave (
    input  RX_DATA, RX_LOAD, RX_STOP,
    output P_ADDR, P_DATA, P_ENA, FRAME_ERR, ERR_CNT
  );
endinterface

// File: rtl/spi_rx_word_deser.sv
// SPI RX front end: assembles RX_LOAD-framed serial bits into WORD_W-bit words, tags each with its
// position in the message, and drops/counts truncated words.
module spi_rx_word_deser #(
  parameter int unsigned WORD_W    = 16,
  parameter int unsigned ADDR_W    = 3,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic                RX_CLK,
  input logic                RST,
  spi_rx_word_deser_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(WORD_W + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WORD_W - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] shift_q, shift_d, shifted;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0] word_idx_q, word_idx_d;
  logic [ADDR_W-1:0] p_addr_q, p_addr_d;
  logic [WORD_W-1:0] p_data_q, p_data_d;
  logic              p_ena_q, p_ena_d;
  logic              frame_err_q, frame_err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              last_bit;

  // Shift register contents once the current RX_DATA bit has been taken in.
  always_comb begin
    if (MSB_FIRST) begin
      shifted = (shift_q << 1) | WORD_W'(bus.RX_DATA);
    end else begin
      shifted             = shift_q >> 1;
      shifted[WORD_W-1]   = bus.RX_DATA;
    end
  end

  // A completing bit wins over RX_STOP: the word is delivered, then the index restarts.
  assign last_bit = bus.RX_LOAD && (bit_cnt_q == LastCnt);

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    word_idx_d  = word_idx_q;
    p_addr_d    = p_addr_q;
    p_data_d    = p_data_q;
    p_ena_d     = 1'b0;
    frame_err_d = 1'b0;
    err_cnt_d   = err_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (last_bit) begin
          p_data_d   = shifted;
          p_addr_d   = word_idx_q;
          word_idx_d = word_idx_q + 1'b1;
          p_ena_d    = 1'b1;
          shift_d    = '0;
          bit_cnt_d  = '0;
        end else if (bus.RX_LOAD && !bus.RX_STOP) begin
          shift_d   = shifted;
          bit_cnt_d = CntW'(1);
          state_d   = StShift;
        end
      end
      StShift: begin
        if (last_bit) begin
          p_data_d   = shifted;
          p_addr_d   = word_idx_q;
          word_idx_d = word_idx_q + 1'b1;
          p_ena_d    = 1'b1;
          shift_d    = '0;
          bit_cnt_d  = '0;
          state_d    = StIdle;
        end else if (bus.RX_STOP || !bus.RX_LOAD) begin
          shift_d     = '0;
          bit_cnt_d   = '0;
          frame_err_d = 1'b1;
          if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
          state_d     = StIdle;
        end else begin
          shift_d   = shifted;
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
    endcase

    if (bus.RX_STOP) begin
      word_idx_d = '0;
    end
  end

  always_ff @(posedge RX_CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      word_idx_q  <= '0;
      p_addr_q    <= '0;
      p_data_q    <= '0;
      p_ena_q     <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      word_idx_q  <= word_idx_d;
      p_addr_q    <= p_addr_d;
      p_data_q    <= p_data_d;
      p_ena_q     <= p_ena_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.P_ADDR    = p_addr_q;
  assign bus.P_DATA    = p_data_q;
  assign bus.P_ENA     = p_ena_q;
  assign bus.FRAME_ERR = frame_err_q;
  assign bus.ERR_CNT   = err_cnt_q;

endmodule

// File: tb/tb_spi_rx_word_deser.sv
// Bench for spi_rx_word_deser: directed scenarios plus random traffic against a bit-list model;
// a negedge monitor checks every cycle.
module tb_spi_rx_word_deser;

  localparam int unsigned W   = 16;
  localparam int unsigned A   = 3;
  localparam bit          MSB = 1'b1;

  logic RX_CLK = 1'b0;
  logic RST    = 1'b0;

  spi_rx_word_deser_if #(.WORD_W(W), .ADDR_W(A)) bus ();

  spi_rx_word_deser #(.WORD_W(W), .ADDR_W(A), .MSB_FIRST(MSB)) dut (
    .RX_CLK (RX_CLK),
    .RST    (RST),
    .bus    (bus)
  );

  always #5 RX_CLK = ~RX_CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: list of bits of the word in progress, message index, error count.
  bit           m_bits[$];
  int           m_idx;
  int           m_err;
  int           m_words;
  logic         exp_ena;
  logic         exp_fe;
  logic [W-1:0] exp_data;
  logic [A-1:0] exp_addr;

  // Monitor observations.
  bit           mon_en = 1'b0;
  int           cyc = 0;
  int           ena_seen = 0;
  int           fe_seen = 0;
  logic [W-1:0] prev_data = '0;
  logic [A+W-1:0] obs_q[$];
  int           obs_cyc[$];

  task automatic model_reset();
    m_bits.delete();
    m_idx   = 0;
    m_err   = 0;
    exp_ena = 1'b0;
    exp_fe  = 1'b0;
  endtask

  task automatic model_trunc();
    exp_fe = 1'b1;
    if (m_err < 255) m_err++;
  endtask

  task automatic model_step(input logic load, input logic din, input logic stop);
    logic [W-1:0] w;
    exp_ena = 1'b0;
    exp_fe  = 1'b0;
    if (load && m_bits.size() == W - 1) begin
      m_bits.push_back(din);
      w = '0;
      for (int i = 0; i < W; i++) begin
        if (MSB) w[W-1-i] = m_bits[i];
        else     w[i]     = m_bits[i];
      end
      exp_data = w;
      exp_addr = A'(m_idx);
      exp_ena  = 1'b1;
      m_words++;
      m_bits.delete();
      m_idx = stop ? 0 : (m_idx + 1) % (1 << A);
    end else if (stop) begin
      if (m_bits.size() != 0) model_trunc();
      m_bits.delete();
      m_idx = 0;
    end else if (load) begin
      m_bits.push_back(din);
    end else if (m_bits.size() != 0) begin
      model_trunc();
      m_bits.delete();
    end
  endtask

  task automatic edge_drive(input logic load, input logic din, input logic stop);
    @(negedge RX_CLK);
    #1;
    bus.RX_LOAD = load;
    bus.RX_DATA = din;
    bus.RX_STOP = stop;
    @(posedge RX_CLK);
    #1;
    model_step(load, din, stop);
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit stop_last);
    for (int i = 0; i < W; i++) begin
      edge_drive(1'b1, MSB ? w[W-1-i] : w[i], stop_last && (i == W - 1));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) edge_drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge RX_CLK);
    #1;
    RST         = 1'b0;
    bus.RX_LOAD = 1'b0;
    bus.RX_DATA = 1'b0;
    bus.RX_STOP = 1'b0;
    model_reset();
    repeat (2) @(negedge RX_CLK);
    #1;
    RST = 1'b1;
  endtask

  always @(negedge RX_CLK) begin
    cyc++;
    if (mon_en) begin
      if (RST === 1'b0) begin
        checks++;
        if ({bus.P_ADDR, bus.P_DATA, bus.P_ENA, bus.FRAME_ERR, bus.ERR_CNT} !== '0) begin
          errors++;
          $display("FAIL in_reset: addr=%0d data=%h ena=%b fe=%b cnt=%0d, required all zero",
                   bus.P_ADDR, bus.P_DATA, bus.P_ENA, bus.FRAME_ERR, bus.ERR_CNT);
        end
        prev_data = '0;
      end else begin
        checks++;
        if (bus.P_ENA !== exp_ena) begin
          errors++;
          $display("FAIL p_ena @%0d: got %b required %b", cyc, bus.P_ENA, exp_ena);
        end
        checks++;
        if (bus.FRAME_ERR !== exp_fe) begin
          errors++;
          $display("FAIL frame_err @%0d: got %b required %b", cyc, bus.FRAME_ERR, exp_fe);
        end
        checks++;
        if (bus.ERR_CNT !== 8'(m_err)) begin
          errors++;
          $display("FAIL err_cnt @%0d: got %0d required %0d", cyc, bus.ERR_CNT, m_err);
        end
        checks++;
        if (bus.P_ENA === 1'b1 && bus.FRAME_ERR === 1'b1) begin
          errors++;
          $display("FAIL ena_fe_mutex @%0d: got both high required at most one", cyc);
        end
        checks++;
        if (exp_ena) begin
          if (bus.P_DATA !== exp_data || bus.P_ADDR !== exp_addr) begin
            errors++;
            $display("FAIL word @%0d: got data=%h addr=%0d required data=%h addr=%0d",
                     cyc, bus.P_DATA, bus.P_ADDR, exp_data, exp_addr);
          end
        end else if (bus.P_DATA !== prev_data) begin
          errors++;
          $display("FAIL p_data_stable @%0d: got %h required held %h", cyc, bus.P_DATA, prev_data);
        end
        if (bus.P_ENA === 1'b1) begin
          ena_seen++;
          obs_q.push_back({bus.P_ADDR, bus.P_DATA});
          obs_cyc.push_back(cyc);
        end
        if (bus.FRAME_ERR === 1'b1) fe_seen++;
        prev_data = bus.P_DATA;
      end
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge RX_CLK);
    #1;
    checks++;
    if (bus.P_ADDR !== '0) begin
      errors++; $display("FAIL reset_p_addr: got %0d required 0", bus.P_ADDR);
    end
    checks++;
    if (bus.P_DATA !== '0) begin
      errors++; $display("FAIL reset_p_data: got %h required 0", bus.P_DATA);
    end
    checks++;
    if (bus.P_ENA !== 1'b0) begin
      errors++; $display("FAIL reset_p_ena: got %b required 0", bus.P_ENA);
    end
    checks++;
    if (bus.FRAME_ERR !== 1'b0) begin
      errors++; $display("FAIL reset_frame_err: got %b required 0", bus.FRAME_ERR);
    end
    checks++;
    if (bus.ERR_CNT !== 8'd0) begin
      errors++; $display("FAIL reset_err_cnt: got %0d required 0", bus.ERR_CNT);
    end
    RST = 1'b1;
  endtask

  task automatic test_single_word();
    do_reset();
    obs_q.delete(); obs_cyc.delete();
    send_word(16'h55AA, 1'b0);
    idle(2);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== {3'd0, 16'h55AA}) begin
      errors++;
      $display("FAIL single_word: got %0d strobes first=%h required 1 strobe addr0 data 55aa",
               obs_q.size(), obs_q.size() != 0 ? obs_q[0] : '0);
    end
    checks++;
    if (bus.ERR_CNT !== 8'd0) begin
      errors++; $display("FAIL single_word_err_cnt: got %0d required 0", bus.ERR_CNT);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    obs_q.delete(); obs_cyc.delete();
    send_word(16'h55AA, 1'b0);
    send_word(16'hFF00, 1'b0);
    idle(2);
    checks++;
    if (obs_q.size() != 2) begin
      errors++; $display("FAIL b2b_count: got %0d required 2", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0] !== {3'd0, 16'h55AA} || obs_q[1] !== {3'd1, 16'hFF00}) begin
        errors++;
        $display("FAIL b2b_words: got %h %h required %h %h", obs_q[0], obs_q[1],
                 {3'd0, 16'h55AA}, {3'd1, 16'hFF00});
      end
      checks++;
      if (obs_cyc[1] - obs_cyc[0] != 16) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d required 16", obs_cyc[1] - obs_cyc[0]);
      end
    end
  endtask

  task automatic test_truncation();
    int fe0;
    do_reset();
    obs_q.delete(); obs_cyc.delete();
    fe0 = fe_seen;
    for (int i = 0; i < 9; i++) edge_drive(1'b1, 1'($urandom_range(1)), 1'b0);
    idle(1);
    send_word(16'h1234, 1'b0);
    idle(2);
    checks++;
    if (fe_seen - fe0 != 1 || bus.ERR_CNT !== 8'd1) begin
      errors++;
      $display("FAIL trunc_err: got pulses=%0d cnt=%0d required 1 and 1", fe_seen - fe0, bus.ERR_CNT);
    end
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== {3'd0, 16'h1234}) begin
      errors++;
      $display("FAIL trunc_next_word: got %0d strobes first=%h required %h",
               obs_q.size(), obs_q.size() != 0 ? obs_q[0] : '0, {3'd0, 16'h1234});
    end
    // Partial word cut by RX_STOP with RX_LOAD high: exactly one error, index restarts.
    obs_q.delete();
    send_word(16'h0F0F, 1'b0);
    for (int i = 0; i < 5; i++) edge_drive(1'b1, 1'b1, 1'b0);
    edge_drive(1'b1, 1'b1, 1'b1);
    send_word(16'hBEEF, 1'b0);
    idle(2);
    checks++;
    if (fe_seen - fe0 != 2 || bus.ERR_CNT !== 8'd2) begin
      errors++;
      $display("FAIL trunc_stop: got pulses=%0d cnt=%0d required 2 and 2", fe_seen - fe0, bus.ERR_CNT);
    end
    checks++;
    if (obs_q.size() != 2 || obs_q[1] !== {3'd0, 16'hBEEF}) begin
      errors++;
      $display("FAIL trunc_stop_word: got %0d strobes last=%h required %h",
               obs_q.size(), obs_q.size() != 0 ? obs_q[obs_q.size()-1] : '0, {3'd0, 16'hBEEF});
    end
  endtask

  task automatic test_stop_and_wrap();
    int exp_a[9] = '{0, 1, 2, 0, 1, 2, 3, 4, 5};
    logic [W-1:0] sent[10];
    do_reset();
    obs_q.delete(); obs_cyc.delete();
    for (int i = 0; i < 9; i++) begin
      sent[i] = W'($urandom);
      send_word(sent[i], i == 2);
    end
    idle(2);
    checks++;
    if (obs_q.size() != 9) begin
      errors++; $display("FAIL stop_count: got %0d required 9", obs_q.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (obs_q[i] !== {3'(exp_a[i]), sent[i]}) begin
          errors++;
          $display("FAIL stop_word%0d: got %h required %h", i, obs_q[i], {3'(exp_a[i]), sent[i]});
        end
      end
    end
    do_reset();
    obs_q.delete();
    for (int i = 0; i < 10; i++) begin
      sent[i] = W'($urandom);
      send_word(sent[i], 1'b0);
    end
    idle(2);
    checks++;
    if (obs_q.size() != 10) begin
      errors++; $display("FAIL wrap_count: got %0d required 10", obs_q.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (obs_q[i] !== {3'(i % 8), sent[i]}) begin
          errors++;
          $display("FAIL wrap_word%0d: got %h required %h", i, obs_q[i], {3'(i % 8), sent[i]});
        end
      end
    end
  endtask

  task automatic test_reset_mid_word();
    int fe0;
    do_reset();
    obs_q.delete();
    fe0 = fe_seen;
    for (int i = 0; i < 7; i++) edge_drive(1'b1, 1'b1, 1'b0);
    do_reset();
    send_word(16'hA5A5, 1'b0);
    idle(2);
    checks++;
    if (fe_seen != fe0 || obs_q.size() != 1 || obs_q[0] !== {3'd0, 16'hA5A5}) begin
      errors++;
      $display("FAIL reset_mid_word: got pulses=%0d strobes=%0d first=%h required 0, 1, %h",
               fe_seen - fe0, obs_q.size(), obs_q.size() != 0 ? obs_q[0] : '0, {3'd0, 16'hA5A5});
    end
  endtask

  task automatic test_err_saturation();
    int fe0;
    int ena0;
    do_reset();
    fe0  = fe_seen;
    ena0 = ena_seen;
    for (int n = 0; n < 300; n++) begin
      int len = $urandom_range(W - 1, 1);
      for (int i = 0; i < len; i++) edge_drive(1'b1, 1'($urandom_range(1)), 1'b0);
      idle(1);
    end
    idle(1);
    checks++;
    if (bus.ERR_CNT !== 8'd255) begin
      errors++; $display("FAIL err_sat: got %0d required 255", bus.ERR_CNT);
    end
    checks++;
    if (fe_seen - fe0 != 300 || ena_seen != ena0) begin
      errors++;
      $display("FAIL err_sat_pulses: got fe=%0d ena=%0d required 300 and 0",
               fe_seen - fe0, ena_seen - ena0);
    end
  endtask

  task automatic test_random();
    int ena0;
    int w0;
    do_reset();
    ena0 = ena_seen;
    w0   = m_words;
    for (int i = 0; i < 3000; i++) begin
      edge_drive(($urandom_range(99) < 92) ? 1'b1 : 1'b0, 1'($urandom_range(1)),
                 ($urandom_range(99) < 2) ? 1'b1 : 1'b0);
    end
    idle(2);
    checks++;
    if (ena_seen - ena0 != m_words - w0) begin
      errors++;
      $display("FAIL random_word_count: got %0d required %0d", ena_seen - ena0, m_words - w0);
    end
  endtask

  initial begin
    bus.RX_LOAD = 1'b0;
    bus.RX_DATA = 1'b0;
    bus.RX_STOP = 1'b0;
    m_words     = 0;
    model_reset();
    mon_en = 1'b1;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_truncation();
    test_stop_and_wrap();
    test_reset_mid_word();
    test_err_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
